// File: rtl/fetch_insn_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_insn_queue
//  Purpose  : Instruction buffer between fetch and decode. Holds up to
//             2**LG_DEPTH fetched entries and presents the oldest one to the
//             decoder through a valid/ready handshake. No bypass path.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_insn_queue #(
  parameter int LG_DEPTH  = 3,
  parameter int AF_SLACK  = 2,
  parameter int M_WIDTH   = 64,
  parameter int LG_PHT_SZ = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  input  logic [31:0]          enq_insn_i,
  input  logic [M_WIDTH-1:0]   enq_pc_i,
  input  logic                 enq_pred_i,
  input  logic [LG_PHT_SZ-1:0] enq_pht_idx_i,
  input  logic [M_WIDTH-1:0]   enq_pred_target_i,
  input  logic [63:0]          enq_fetch_cycle_i,
  output logic                 deq_valid_o,
  input  logic                 deq_ready_i,
  output logic [31:0]          deq_insn_o,
  output logic [M_WIDTH-1:0]   deq_pc_o,
  output logic                 deq_pred_o,
  output logic [LG_PHT_SZ-1:0] deq_pht_idx_o,
  output logic [M_WIDTH-1:0]   deq_pred_target_o,
  output logic [63:0]          deq_fetch_cycle_o,
  output logic                 almost_full_o,
  output logic [LG_DEPTH:0]    occupancy_o
);

  localparam int DEPTH = 1 << LG_DEPTH;
  localparam logic [LG_DEPTH:0] PTR_ONE   = (LG_DEPTH+1)'(1);
  localparam logic [LG_DEPTH:0] AF_THRESH = (LG_DEPTH+1)'(DEPTH - AF_SLACK);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [LG_DEPTH:0] head_q, head_d;
  logic [LG_DEPTH:0] tail_q, tail_d;

  // Entry storage, one array per field, indexed by the pointer low bits.
  logic [31:0]          insn_q   [DEPTH];
  logic [M_WIDTH-1:0]   pc_q     [DEPTH];
  logic                 pred_q   [DEPTH];
  logic [LG_PHT_SZ-1:0] pht_q    [DEPTH];
  logic [M_WIDTH-1:0]   target_q [DEPTH];
  logic [63:0]          cycle_q  [DEPTH];

  logic                w_empty;
  logic                w_full;
  logic                w_enq_fire;
  logic                w_deq_fire;
  logic [LG_DEPTH-1:0] w_head_idx;
  logic [LG_DEPTH-1:0] w_tail_idx;

  assign w_head_idx = head_q[LG_DEPTH-1:0];
  assign w_tail_idx = tail_q[LG_DEPTH-1:0];
  assign w_empty    = (head_q == tail_q);
  assign w_full     = (head_q[LG_DEPTH-1:0] == tail_q[LG_DEPTH-1:0]) &&
                      (head_q[LG_DEPTH] != tail_q[LG_DEPTH]);

  // Flush wins over both sides, so neither handshake counts during a flush.
  assign w_enq_fire = enq_valid_i && !w_full && !flush_i;
  assign w_deq_fire = deq_ready_i && !w_empty && !flush_i;

  assign enq_ready_o   = !w_full;
  assign deq_valid_o   = !w_empty;
  assign occupancy_o   = tail_q - head_q;
  assign almost_full_o = (occupancy_o >= AF_THRESH);

  // Head entry fields are forced to zero when empty so decode sees a nop.
  assign deq_insn_o        = w_empty ? '0 : insn_q[w_head_idx];
  assign deq_pc_o          = w_empty ? '0 : pc_q[w_head_idx];
  assign deq_pred_o        = w_empty ? 1'b0 : pred_q[w_head_idx];
  assign deq_pht_idx_o     = w_empty ? '0 : pht_q[w_head_idx];
  assign deq_pred_target_o = w_empty ? '0 : target_q[w_head_idx];
  assign deq_fetch_cycle_o = w_empty ? '0 : cycle_q[w_head_idx];

  // Next pointer values: flush clears both, otherwise advance on each fire.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (w_enq_fire) tail_d = tail_q + PTR_ONE;
      if (w_deq_fire) head_d = head_q + PTR_ONE;
    end
  end

  // Pointer registers; reset discards all contents immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Write the accepted entry into the tail slot; storage is never cleared.
  always_ff @(posedge clk_i) begin
    if (w_enq_fire) begin
      insn_q[w_tail_idx]   <= enq_insn_i;
      pc_q[w_tail_idx]     <= enq_pc_i;
      pred_q[w_tail_idx]   <= enq_pred_i;
      pht_q[w_tail_idx]    <= enq_pht_idx_i;
      target_q[w_tail_idx] <= enq_pred_target_i;
      cycle_q[w_tail_idx]  <= enq_fetch_cycle_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_insn_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_insn_queue
//  Purpose  : Self-checking bench for fetch_insn_queue: vector table for
//             fill/drain, scoreboard-driven sequences for wrap, full,
//             flush and asynchronous reset corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_insn_queue;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [31:0] enq_insn_i;
  logic [63:0] enq_pc_i;
  logic        enq_pred_i;
  logic [15:0] enq_pht_idx_i;
  logic [63:0] enq_pred_target_i;
  logic [63:0] enq_fetch_cycle_i;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [31:0] deq_insn_o;
  logic [63:0] deq_pc_o;
  logic        deq_pred_o;
  logic [15:0] deq_pht_idx_o;
  logic [63:0] deq_pred_target_o;
  logic [63:0] deq_fetch_cycle_o;
  logic        almost_full_o;
  logic [3:0]  occupancy_o;

  int checks = 0;
  int errors = 0;

  fetch_insn_queue #(
    .LG_DEPTH (3),
    .AF_SLACK (2),
    .M_WIDTH  (64),
    .LG_PHT_SZ(16)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .flush_i          (flush_i),
    .enq_valid_i      (enq_valid_i),
    .enq_ready_o      (enq_ready_o),
    .enq_insn_i       (enq_insn_i),
    .enq_pc_i         (enq_pc_i),
    .enq_pred_i       (enq_pred_i),
    .enq_pht_idx_i    (enq_pht_idx_i),
    .enq_pred_target_i(enq_pred_target_i),
    .enq_fetch_cycle_i(enq_fetch_cycle_i),
    .deq_valid_o      (deq_valid_o),
    .deq_ready_i      (deq_ready_i),
    .deq_insn_o       (deq_insn_o),
    .deq_pc_o         (deq_pc_o),
    .deq_pred_o       (deq_pred_o),
    .deq_pht_idx_o    (deq_pht_idx_o),
    .deq_pred_target_o(deq_pred_target_o),
    .deq_fetch_cycle_o(deq_fetch_cycle_o),
    .almost_full_o    (almost_full_o),
    .occupancy_o      (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  // Side fields are derived from the PC so mixed-up entries are visible.
  function automatic logic [31:0] mk_insn(input logic [63:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Head-entry check; when not valid every field must read zero.
  task automatic chk_head(input string tag, input logic exp_valid,
                          input logic [31:0] exp_insn, input logic [63:0] exp_pc);
    chk({tag, ".valid"}, 64'(deq_valid_o), 64'(exp_valid));
    chk({tag, ".insn"},  64'(deq_insn_o),  64'(exp_insn));
    chk({tag, ".pc"},    deq_pc_o,         exp_valid ? exp_pc : 64'd0);
    chk({tag, ".pred"},  64'(deq_pred_o),  exp_valid ? 64'(exp_pc[2]) : 64'd0);
    chk({tag, ".pht"},   64'(deq_pht_idx_o), exp_valid ? 64'(exp_pc[17:2]) : 64'd0);
    chk({tag, ".tgt"},   deq_pred_target_o, exp_valid ? exp_pc + 64'h100 : 64'd0);
    chk({tag, ".cyc"},   deq_fetch_cycle_o, exp_valid ? exp_pc * 3 : 64'd0);
  endtask

  task automatic drive(input logic en, input logic dr, input logic fl,
                       input logic [31:0] insn, input logic [63:0] pc);
    enq_valid_i       = en;
    deq_ready_i       = dr;
    flush_i           = fl;
    enq_insn_i        = insn;
    enq_pc_i          = pc;
    enq_pred_i        = pc[2];
    enq_pht_idx_i     = pc[17:2];
    enq_pred_target_i = pc + 64'h100;
    enq_fetch_cycle_i = pc * 3;
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Structural invariants sampled away from the active edge.
  always @(negedge clk_i) begin
    if (reset_i === 1'b0) begin
      chk("inv.occ_le_depth", 64'(occupancy_o <= 4'd8), 64'd1);
      chk("inv.not_full_and_empty", 64'(!(!deq_valid_o && !enq_ready_o)), 64'd1);
    end
  end

  // Fill/drain vector table: inputs for one cycle plus the outputs expected
  // in that cycle (before the edge that applies the inputs).
  typedef struct {
    logic        en;
    logic        dr;
    logic        fl;
    logic [31:0] insn;
    logic [63:0] pc;
    logic        e_valid;
    logic        e_ready;
    logic        e_af;
    logic [3:0]  e_occ;
    logic [31:0] e_insn;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[19];

  // Scoreboard for the sequence tests: PCs in expected dequeue order.
  logic [63:0] mq[$];

  // One scoreboarded cycle: check outputs against the model, then clock.
  task automatic step(input string tag, input logic en, input logic dr,
                      input logic fl, input logic [63:0] pc);
    int  sz;
    logic en_f;
    logic de_f;
    sz = mq.size();
    drive(en, dr, fl, mk_insn(pc), pc);
    #1;
    chk({tag, ".occ"},   64'(occupancy_o),   64'(sz));
    chk({tag, ".ready"}, 64'(enq_ready_o),   64'(sz < 8));
    chk({tag, ".af"},    64'(almost_full_o), 64'(sz >= 6));
    if (sz > 0) chk_head(tag, 1'b1, mk_insn(mq[0]), mq[0]);
    else        chk_head(tag, 1'b0, 32'd0, 64'd0);
    en_f = en && (sz < 8);
    de_f = dr && (sz > 0);
    tick();
    if (fl) mq.delete();
    else begin
      if (de_f) void'(mq.pop_front());
      if (en_f) mq.push_back(pc);
    end
  endtask

  initial begin
    // Build the table.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 64'd0};
    for (int i = 0; i < 8; i++)
      vecs[1+i] = '{1'b1, 1'b0, 1'b0, 32'h13 + i, 64'h1000 + 4*i,
                    (i > 0), 1'b1, (i >= 6), 4'(i),
                    (i > 0) ? 32'h13 : 32'd0, (i > 0) ? 64'h1000 : 64'd0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h99, 64'h9990, 1'b1, 1'b0, 1'b1, 4'd8, 32'h13, 64'h1000};
    for (int k = 0; k < 8; k++)
      vecs[10+k] = '{1'b0, 1'b1, 1'b0, 32'd0, 64'd0,
                     1'b1, (k > 0), ((8 - k) >= 6), 4'(8 - k),
                     32'h13 + k, 64'h1000 + 4*k};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 64'd0};

    // Reset state, checked while reset is held.
    reset_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    repeat (2) @(negedge clk_i);
    chk("rst.valid", 64'(deq_valid_o), 64'd0);
    chk("rst.ready", 64'(enq_ready_o), 64'd1);
    chk("rst.af",    64'(almost_full_o), 64'd0);
    chk("rst.occ",   64'(occupancy_o), 64'd0);
    chk("rst.insn",  64'(deq_insn_o), 64'd0);
    reset_i = 1'b0;
    tick();

    // Fill to full, ignore a 9th enqueue, drain in order.
    for (int v = 0; v < 19; v++) begin
      drive(vecs[v].en, vecs[v].dr, vecs[v].fl, vecs[v].insn, vecs[v].pc);
      enq_pred_i        = 1'b0;
      enq_pht_idx_i     = vecs[v].pc[17:2];
      #1;
      chk($sformatf("vec%0d.valid", v), 64'(deq_valid_o),   64'(vecs[v].e_valid));
      chk($sformatf("vec%0d.ready", v), 64'(enq_ready_o),   64'(vecs[v].e_ready));
      chk($sformatf("vec%0d.af", v),    64'(almost_full_o), 64'(vecs[v].e_af));
      chk($sformatf("vec%0d.occ", v),   64'(occupancy_o),   64'(vecs[v].e_occ));
      chk($sformatf("vec%0d.insn", v),  64'(deq_insn_o),    64'(vecs[v].e_insn));
      chk($sformatf("vec%0d.pc", v),    deq_pc_o,           vecs[v].e_pc);
      chk($sformatf("vec%0d.tgt", v),   deq_pred_target_o,
          vecs[v].e_valid ? vecs[v].e_pc + 64'h100 : 64'd0);
      tick();
    end

    // Steady state at occupancy 4 with simultaneous enq/deq across wraps.
    for (int i = 0; i < 4; i++) step("wrap.fill", 1'b1, 1'b0, 1'b0, 64'h4000 + 4*i);
    for (int i = 4; i < 24; i++) step("wrap", 1'b1, 1'b1, 1'b0, 64'h4000 + 4*i);
    #1 chk("wrap.occ_final", 64'(occupancy_o), 64'd4);

    // Full queue: simultaneous enq/deq only dequeues; enq entry is dropped.
    step("full.flush", 1'b0, 1'b0, 1'b1, 64'd0);
    for (int i = 0; i < 8; i++) step("full.fill", 1'b1, 1'b0, 1'b0, 64'h6000 + 4*i);
    step("full.both", 1'b1, 1'b1, 1'b0, 64'hDEAD0);
    #1 chk("full.occ_after", 64'(occupancy_o), 64'd7);
    for (int i = 0; i < 7; i++) step("full.drain", 1'b0, 1'b1, 1'b0, 64'd0);
    step("full.empty", 1'b0, 1'b0, 1'b0, 64'd0);

    // Flush beats concurrent enq and deq.
    for (int i = 0; i < 5; i++) step("fl.fill", 1'b1, 1'b0, 1'b0, 64'h7000 + 4*i);
    step("fl.flush", 1'b1, 1'b1, 1'b1, 64'h5550);
    #1;
    chk("fl.occ0",   64'(occupancy_o), 64'd0);
    chk("fl.valid0", 64'(deq_valid_o), 64'd0);
    step("fl.enq", 1'b1, 1'b0, 1'b0, 64'h2000);
    #1 chk("fl.head_pc", deq_pc_o, 64'h2000);
    step("fl.idle", 1'b0, 1'b1, 1'b0, 64'd0);

    // Asynchronous reset mid-cycle with three entries resident.
    for (int i = 0; i < 3; i++) step("ar.fill", 1'b1, 1'b0, 1'b0, 64'h8000 + 4*i);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    #1 chk("ar.pre_valid", 64'(deq_valid_o), 64'd1);
    #1 reset_i = 1'b1;
    #1;
    chk("ar.valid", 64'(deq_valid_o), 64'd0);
    chk("ar.occ",   64'(occupancy_o), 64'd0);
    chk("ar.insn",  64'(deq_insn_o),  64'd0);
    chk("ar.ready", 64'(enq_ready_o), 64'd1);
    mq.delete();
    @(negedge clk_i);
    reset_i = 1'b0;
    step("ar.enq", 1'b1, 1'b0, 1'b0, 64'h3000);
    step("ar.head", 1'b0, 1'b1, 1'b0, 64'd0);
    step("ar.end", 1'b0, 1'b0, 1'b0, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
